// File: rtl/adder_share_arb.sv
// One W-bit ripple adder shared by four requesters; result registered one cycle after acceptance and held until rsp_ready.
// Requests are stalled while a result is held; round-robin arbitration with ADDER_ARB_RR_EN defined, fixed priority otherwise.
module adder_share_arb #(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [W:0]        rsp_sum,
    output logic [1:0]        rsp_id,
    input  logic              rsp_ready,
    output logic              busy,
    output logic [15:0]       op_count
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [W:0]  rsp_sum_q, rsp_sum_d;
    logic [1:0]  rsp_id_q, rsp_id_d;
    logic [15:0] op_count_q, op_count_d;

    logic        grant_vld;
    logic [1:0]  grant_idx;
    logic        accept;
    logic        xfer;
    logic [W-1:0] op_a, op_b;
    logic [W:0]   add_sum;
    logic [NREQ-1:0] rdy_vec;

`ifdef ADDER_ARB_RR_EN
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] cand;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        cand      = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr_q + 2'(k);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end
`else
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                grant_vld = 1'b1;
                grant_idx = 2'(k);
            end
        end
    end
`endif

    // Reset gating keeps req_ready low while rst_n is held, even though state already reads IDLE.
    assign accept = (state_q == IDLE) || rsp_ready;
    assign xfer   = rst_n && accept && grant_vld;

    assign op_a = req_a[grant_idx*W +: W];
    assign op_b = req_b[grant_idx*W +: W];

    always_comb begin
        logic c;
        c       = 1'b0;
        add_sum = '0;
        for (int i = 0; i < W; i++) begin
            add_sum[i] = op_a[i] ^ op_b[i] ^ c;
            c          = (op_a[i] & op_b[i]) | (c & (op_a[i] ^ op_b[i]));
        end
        add_sum[W] = c;
    end

    always_comb begin
        rdy_vec = '0;
        if (xfer) begin
            rdy_vec[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_id_d   = rsp_id_q;
        op_count_d = op_count_q;
        if (xfer) begin
            state_d    = RESP;
            rsp_sum_d  = add_sum;
            rsp_id_d   = grant_idx;
            op_count_d = op_count_q + 16'd1;
        end else if (state_q == RESP && rsp_ready) begin
            state_d = IDLE;
        end
    end

`ifdef ADDER_ARB_RR_EN
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = grant_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rsp_sum_q  <= '0;
            rsp_id_q   <= 2'd0;
            op_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_id_q   <= rsp_id_d;
            op_count_q <= op_count_d;
        end
    end

    assign req_ready = rdy_vec;
    assign rsp_valid = (state_q == RESP);
    assign busy      = rsp_valid;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb; expected ids follow ADDER_ARB_RR_EN when defined.
module tb_adder_share_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [4:0]  rsp_sum;
    logic [1:0]  rsp_id;
    logic        rsp_ready;
    logic        busy;
    logic [15:0] op_count;

    int err_cnt = 0;
    int chk_cnt = 0;

    adder_share_arb #(.NREQ(4), .W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    // Requester i: a = i+1, b = i+5, so sum = 2i+6.
    function automatic logic [4:0] exp_sum(input int id);
        return 5'(2 * id + 6);
    endfunction

    int exp_ids[5];
    int exp_n;
    int held_id;
    int next_id;

    initial begin
`ifdef ADDER_ARB_RR_EN
        exp_ids = '{0, 1, 2, 3, 0};
        next_id = 1;
`else
        exp_ids = '{0, 0, 0, 0, 0};
        next_id = 0;
`endif
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_a     = 16'h0000;
        req_b     = 16'h0000;
        rsp_ready = 1'b0;
        #3;
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_sum",   32'(rsp_sum), 0);
        chk("rst_rsp_id",    32'(rsp_id), 0);
        chk("rst_op_count",  32'(op_count), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_busy",      32'(busy), 0);
        #9;
        rst_n = 1'b1;
        tick();

        // Single request on requester 0: 3+5.
        req_valid = 4'b0001;
        req_a     = 16'h0003;
        req_b     = 16'h0005;
        rsp_ready = 1'b1;
        #1;
        chk("r0_req_ready", 32'(req_ready), 32'h1);
        tick();
        chk("r0_rsp_valid", 32'(rsp_valid), 1);
        chk("r0_rsp_sum",   32'(rsp_sum), 32'h8);
        chk("r0_rsp_id",    32'(rsp_id), 0);
        chk("r0_op_count",  32'(op_count), 1);
        chk("r0_busy",      32'(busy), 1);
        req_valid = 4'b0000;
        #1;
        chk("r0_no_ready", 32'(req_ready), 0);
        tick();
        chk("r0_drain", 32'(rsp_valid), 0);

        // Carry out on requester 2: F+F.
        req_valid = 4'b0100;
        req_a     = 16'h0F00;
        req_b     = 16'h0F00;
        #1;
        chk("ff_req_ready", 32'(req_ready), 32'h4);
        tick();
        chk("ff_rsp_sum",  32'(rsp_sum), 32'h1E);
        chk("ff_rsp_id",   32'(rsp_id), 2);
        chk("ff_op_count", 32'(op_count), 2);
        req_valid = 4'b0000;
        tick();

        // All four requesting, consumer always ready.
        do_reset();
        chk("rst2_op_count", 32'(op_count), 0);
        req_a     = 16'h4321;
        req_b     = 16'h8765;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        exp_n = 0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("all_req_ready%0d", k), 32'(req_ready), 32'(1 << exp_ids[k]));
            tick();
            exp_n++;
            chk($sformatf("all_rsp_id%0d", k), 32'(rsp_id), 32'(exp_ids[k]));
            chk($sformatf("all_rsp_sum%0d", k), 32'(rsp_sum), 32'(exp_sum(exp_ids[k])));
        end
        chk("all_op_count", 32'(op_count), 32'(exp_n));

        // Backpressure: result held for five cycles.
        held_id   = exp_ids[4];
        rsp_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold_req_ready%0d", k), 32'(req_ready), 0);
            chk($sformatf("hold_rsp_id%0d", k), 32'(rsp_id), 32'(held_id));
            chk($sformatf("hold_rsp_sum%0d", k), 32'(rsp_sum), 32'(exp_sum(held_id)));
            chk($sformatf("hold_rsp_valid%0d", k), 32'(rsp_valid), 1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("release_req_ready", 32'(req_ready), 32'(1 << next_id));
        tick();
        exp_n++;
        chk("release_rsp_id",   32'(rsp_id), 32'(next_id));
        chk("release_rsp_sum",  32'(rsp_sum), 32'(exp_sum(next_id)));
        chk("release_op_count", 32'(op_count), 32'(exp_n));

        // Drain to IDLE, then idle with nothing pending.
        req_valid = 4'b0000;
        tick();
        chk("drain_rsp_valid", 32'(rsp_valid), 0);
        chk("drain_busy",      32'(busy), 0);
        tick();
        chk("idle_rsp_valid", 32'(rsp_valid), 0);
        chk("idle_op_count",  32'(op_count), 32'(exp_n));

        // Only requester 3.
        req_valid = 4'b1000;
        #1;
        chk("r3_req_ready", 32'(req_ready), 32'h8);
        tick();
        exp_n++;
        chk("r3_rsp_id",   32'(rsp_id), 3);
        chk("r3_rsp_sum",  32'(rsp_sum), 32'hC);
        chk("r3_op_count", 32'(op_count), 32'(exp_n));

        // Asynchronous reset mid-cycle while a result is held.
        rsp_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(rsp_valid), 0);
        chk("arst_rsp_sum",   32'(rsp_sum), 0);
        chk("arst_rsp_id",    32'(rsp_id), 0);
        chk("arst_op_count",  32'(op_count), 0);
        chk("arst_req_ready", 32'(req_ready), 0);
        req_valid = 4'b0000;
        #1;
        rst_n = 1'b1;
        tick();
        chk("arst_after_valid", 32'(rsp_valid), 0);
        chk("arst_after_count", 32'(op_count), 0);

        // op_count wrap after 65536 back-to-back transfers.
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            tick();
        end
        chk("wrap_ffff", 32'(op_count), 32'hFFFF);
        tick();
        chk("wrap_zero", 32'(op_count), 0);
        chk("wrap_rsp_valid", 32'(rsp_valid), 1);
        req_valid = 4'b0000;
        tick();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
